// File: rtl/scan_sequencer.sv
// Purpose: prescaled 0..7 scan-index generator for a 3-to-8 decoder select (up/down/ping-pong/hold).
// Latency: sel/tick/wrap are registered and change together on the step edge; load takes effect next edge.
// Backpressure: none; en=0 freezes the prescaler and index, load is honoured regardless of en.
//
// Ports:
//   clk       system clock, all state on rising edge
//   rst_n     synchronous active-low reset
//   en        prescaler/sequencer enable
//   mode      00 up, 01 down, 10 ping-pong, 11 hold
//   load      synchronous load strobe, load_val -> sel
//   load_val  index to load
//   div       step period minus one, in enabled clk cycles
//   sel       current scan index
//   tick      one-cycle pulse on each index step
//   wrap      one-cycle pulse at sequence completion (subset of tick)
module scan_sequencer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic                 load,
    input  logic [2:0]           load_val,
    input  logic [DIV_WIDTH-1:0] div,
    output logic [2:0]           sel,
    output logic                 tick,
    output logic                 wrap
);

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_PING = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

    logic [DIV_WIDTH-1:0] pre;
    logic                 dir;

    logic [DIV_WIDTH-1:0] pre_nxt;
    logic                 dir_nxt;
    logic [2:0]           sel_nxt;
    logic                 tick_nxt;
    logic                 wrap_nxt;
    logic                 step;

    // Equality compare only: if div shrinks below pre, pre keeps counting
    // and wraps around the full counter range before the next step.
    assign step = en && (pre == div);

    always_comb begin
        pre_nxt  = pre;
        dir_nxt  = dir;
        sel_nxt  = sel;
        tick_nxt = 1'b0;
        wrap_nxt = 1'b0;

        if (load) begin
            sel_nxt = load_val;
            pre_nxt = '0;
            dir_nxt = 1'b0;
        end else if (step) begin
            pre_nxt = '0;
            case (mode_t'(mode))
                MODE_UP: begin
                    sel_nxt  = sel + 3'd1;
                    tick_nxt = 1'b1;
                    wrap_nxt = (sel == 3'd7);
                end
                MODE_DOWN: begin
                    sel_nxt  = sel - 3'd1;
                    tick_nxt = 1'b1;
                    wrap_nxt = (sel == 3'd0);
                end
                MODE_PING: begin
                    tick_nxt = 1'b1;
                    if (!dir && sel == 3'd7) begin
                        sel_nxt = 3'd6;
                        dir_nxt = 1'b1;
                    end else if (dir && sel == 3'd0) begin
                        // Bounce off the bottom closes one full ping-pong lap.
                        sel_nxt  = 3'd1;
                        dir_nxt  = 1'b0;
                        wrap_nxt = 1'b1;
                    end else if (dir) begin
                        sel_nxt = sel - 3'd1;
                    end else begin
                        sel_nxt = sel + 3'd1;
                    end
                end
                default: begin
                    // Hold: prescaler still rolls over, index and pulses stay quiet.
                end
            endcase
        end else if (en) begin
            pre_nxt = pre + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre  <= '0;
            dir  <= 1'b0;
            sel  <= 3'd0;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else begin
            pre  <= pre_nxt;
            dir  <= dir_nxt;
            sel  <= sel_nxt;
            tick <= tick_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule
